mem_wrb_stage: RTL and testbench



---
 rtl/mem_wrb_pkg.sv | 22 ++
 rtl/wrb_dec_pkg.sv | 10 +
 rtl/wrb_load_align.sv | 34 +++
 rtl/mem_wrb_stage.sv | 106 ++++++++++
 tb/tb_mem_wrb_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_wrb_pkg.sv
// Memory->writeback channel types and load-size encoding.
package mem_wrb_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2
    } ld_size_e;

    typedef struct packed {
        logic            we;
        logic [4:0]      rd;
        logic            is_load;
        ld_size_e        ld_size;
        logic            ld_signed;
        logic [1:0]      addr_lo;
        logic [XLEN-1:0] alu_data;
    } mem_wrb_pkt_t;

endpackage

// File: rtl/wrb_dec_pkg.sv
// Writeback->decode channel types shared with the decode stage.
package wrb_dec_pkg;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wrb_dec_pkt_t;

endpackage

// File: rtl/wrb_load_align.sv
// Little-endian byte/half select and sign/zero extension of a returned load word.
module wrb_load_align
    import mem_wrb_pkg::*;
(
    input  logic [XLEN-1:0] rsp,
    input  ld_size_e        ld_size,
    input  logic [1:0]      addr_lo,
    input  logic            ld_signed,
    output logic [XLEN-1:0] data
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rsp[8*gi +: 8];
        end
    endgenerate

    // Half select looks only at addr_lo[1]; odd half addresses never reach here.
    always_comb begin
        byte_sel = lane[addr_lo];
        half_sel = addr_lo[1] ? rsp[31:16] : rsp[15:0];
        case (ld_size)
            LD_B:    data = {{24{ld_signed & byte_sel[7]}}, byte_sel};
            LD_H:    data = {{16{ld_signed & half_sel[15]}}, half_sel};
            default: data = rsp;
        endcase
    end

endmodule

// File: rtl/mem_wrb_stage.sv
// Writeback stage: in-order retire queue, load-response buffer, registered writeback to decode.
module mem_wrb_stage
    import mem_wrb_pkg::*;
    import wrb_dec_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_wrb_vld,
    input  mem_wrb_pkt_t      mem_wrb_pkt,
    output logic              mem_wrb_stall,
    input  logic              dmem_rsp_vld,
    input  logic [DATA_W-1:0] dmem_rsp_data,
    output logic              wrb_dec_vld,
    output wrb_dec_pkt_t      wrb_dec_pkt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    mem_wrb_pkt_t      q_mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              rsp_buf_vld_reg;
    logic [DATA_W-1:0] rsp_buf_data_reg;
    logic              wrb_dec_vld_reg;
    wrb_dec_pkt_t      wrb_dec_pkt_reg;

    mem_wrb_pkt_t      head;
    logic              head_vld, deq, enq, use_buf, bypass, capture;
    logic [DATA_W-1:0] ld_rsp, ld_data;

    assign mem_wrb_stall = (count_reg == CNT_W'(DEPTH));
    assign enq           = mem_wrb_vld & ~mem_wrb_stall;
    assign head          = q_mem_reg[rd_ptr_reg];
    assign head_vld      = (count_reg != '0);
    assign deq           = head_vld & (~head.is_load | rsp_buf_vld_reg | dmem_rsp_vld);

    // A buffered response is always older than one arriving now, so it is used first.
    assign use_buf = deq & head.is_load & rsp_buf_vld_reg;
    assign bypass  = deq & head.is_load & ~rsp_buf_vld_reg & dmem_rsp_vld;
    assign capture = dmem_rsp_vld & ~bypass;
    assign ld_rsp  = rsp_buf_vld_reg ? rsp_buf_data_reg : dmem_rsp_data;

    wrb_load_align u_align (
        .rsp       (ld_rsp),
        .ld_size   (head.ld_size),
        .addr_lo   (head.addr_lo),
        .ld_signed (head.ld_signed),
        .data      (ld_data)
    );

    always_ff @(posedge clk) begin
        if (enq) begin
            q_mem_reg[wr_ptr_reg] <= mem_wrb_pkt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg       <= '0;
            rd_ptr_reg       <= '0;
            count_reg        <= '0;
            rsp_buf_vld_reg  <= 1'b0;
            rsp_buf_data_reg <= '0;
            wrb_dec_vld_reg  <= 1'b0;
            wrb_dec_pkt_reg  <= '0;
        end else begin
            if (enq) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (deq) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
            if (capture) begin
                rsp_buf_vld_reg  <= 1'b1;
                rsp_buf_data_reg <= dmem_rsp_data;
            end else if (use_buf) begin
                rsp_buf_vld_reg  <= 1'b0;
            end
            wrb_dec_vld_reg <= deq;
            if (deq) begin
                wrb_dec_pkt_reg.we   <= head.we;
                wrb_dec_pkt_reg.rd   <= head.rd;
                wrb_dec_pkt_reg.data <= head.is_load ? ld_data : head.alu_data;
            end
        end
    end

    assign wrb_dec_vld = wrb_dec_vld_reg;
    assign wrb_dec_pkt = wrb_dec_pkt_reg;

    // With one buffer slot, a new response may only land when the slot is being drained.
    a_rsp_overflow: assert property (@(posedge clk) disable iff (reset)
        (dmem_rsp_vld && rsp_buf_vld_reg) |-> use_buf);
    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        mem_wrb_vld |-> !mem_wrb_stall);

endmodule

// File: tb/tb_mem_wrb_stage.sv
// Directed self-checking bench for the writeback stage.
module tb_mem_wrb_stage;
    import mem_wrb_pkg::*;
    import wrb_dec_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         mem_wrb_vld;
    mem_wrb_pkt_t mem_wrb_pkt;
    logic         mem_wrb_stall;
    logic         dmem_rsp_vld;
    logic [31:0]  dmem_rsp_data;
    logic         wrb_dec_vld;
    wrb_dec_pkt_t wrb_dec_pkt;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_wrb_stage #(.DEPTH(2), .DATA_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_wrb_vld   (mem_wrb_vld),
        .mem_wrb_pkt   (mem_wrb_pkt),
        .mem_wrb_stall (mem_wrb_stall),
        .dmem_rsp_vld  (dmem_rsp_vld),
        .dmem_rsp_data (dmem_rsp_data),
        .wrb_dec_vld   (wrb_dec_vld),
        .wrb_dec_pkt   (wrb_dec_pkt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic mem_wrb_pkt_t mk_alu(logic we, logic [4:0] rd, logic [31:0] d);
        mem_wrb_pkt_t p;
        p = '0;
        p.we = we; p.rd = rd; p.alu_data = d;
        return p;
    endfunction

    function automatic mem_wrb_pkt_t mk_ld(logic [4:0] rd, logic [1:0] sz, logic sgn, logic [1:0] a);
        mem_wrb_pkt_t p;
        p = '0;
        p.we = 1'b1; p.rd = rd; p.is_load = 1'b1;
        p.ld_size = ld_size_e'(sz); p.ld_signed = sgn; p.addr_lo = a;
        return p;
    endfunction

    function automatic wrb_dec_pkt_t mk_out(logic we, logic [4:0] rd, logic [31:0] d);
        wrb_dec_pkt_t p;
        p.we = we; p.rd = rd; p.data = d;
        return p;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_wrb_vld = 1'b0; mem_wrb_pkt = '0;
        dmem_rsp_vld = 1'b0; dmem_rsp_data = '0;
        step(); step();
        reset = 1'b0;
        vec_cnt++;
        if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL reset_vld: got %b want 0", wrb_dec_vld); end
        vec_cnt++;
        if (wrb_dec_pkt !== '0) begin err_cnt++; $display("FAIL reset_pkt: got %h want 0", wrb_dec_pkt); end
        vec_cnt++;
        if (mem_wrb_stall !== 1'b0) begin err_cnt++; $display("FAIL reset_stall: got %b want 0", mem_wrb_stall); end
        $display("reset: outputs checked");
    endtask

    task automatic test_alu_latency();
        wrb_dec_pkt_t exp;
        exp = mk_out(1'b1, 5'd5, 32'h1234_5678);
        mem_wrb_pkt = mk_alu(1'b1, 5'd5, 32'h1234_5678); mem_wrb_vld = 1'b1;
        step(); mem_wrb_vld = 1'b0;
        vec_cnt++;
        if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL alu_lat_c1: vld got %b want 0", wrb_dec_vld); end
        step();
        vec_cnt++;
        if (wrb_dec_vld !== 1'b1 || wrb_dec_pkt !== exp) begin
            err_cnt++; $display("FAIL alu_lat_c2: got vld=%b pkt=%h want vld=1 pkt=%h", wrb_dec_vld, wrb_dec_pkt, exp);
        end
        step();
        vec_cnt++;
        if (wrb_dec_vld !== 1'b0 || wrb_dec_pkt !== exp) begin
            err_cnt++; $display("FAIL alu_hold: got vld=%b pkt=%h want vld=0 pkt=%h", wrb_dec_vld, wrb_dec_pkt, exp);
        end
        $display("alu: rd=5 data=%h emitted in cycle 2", wrb_dec_pkt.data);
    endtask

    task automatic test_load_align();
        logic [1:0]  sz  [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic        sg  [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0]  al  [9] = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd3, 2'd1, 2'd0, 2'd0, 2'd0};
        logic [31:0] rsp [9] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_7FFF, 32'h8001_7FFF,
                                 32'hA1B2_C3D4, 32'h1234_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_007F};
        logic [31:0] exp [9] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_7FFF,
                                 32'h0000_00A1, 32'hFFFF_F00D, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_007F};
        for (int i = 0; i < 9; i++) begin
            logic [4:0] rd;
            rd = 5'(i + 10);
            mem_wrb_pkt = mk_ld(rd, sz[i], sg[i], al[i]); mem_wrb_vld = 1'b1;
            step(); mem_wrb_vld = 1'b0;
            vec_cnt++;
            if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL ld%0d_wait1: vld got %b want 0", i, wrb_dec_vld); end
            step();
            dmem_rsp_vld = 1'b1; dmem_rsp_data = rsp[i];
            vec_cnt++;
            if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL ld%0d_wait2: vld got %b want 0", i, wrb_dec_vld); end
            step();
            dmem_rsp_vld = 1'b0; dmem_rsp_data = '0;
            vec_cnt++;
            if (wrb_dec_vld !== 1'b1 || wrb_dec_pkt !== mk_out(1'b1, rd, exp[i])) begin
                err_cnt++;
                $display("FAIL ld%0d_data: got vld=%b pkt=%h want vld=1 pkt=%h", i, wrb_dec_vld, wrb_dec_pkt, mk_out(1'b1, rd, exp[i]));
            end
            $display("load %0d: size=%0d signed=%0b addr_lo=%0d rsp=%h -> %h", i, sz[i], sg[i], al[i], rsp[i], wrb_dec_pkt.data);
            step();
        end
    endtask

    task automatic test_load_stall();
        mem_wrb_pkt_t plan [3];
        wrb_dec_pkt_t exp [3];
        wrb_dec_pkt_t got [$];
        int issued = 0;
        int first_cyc = -1;
        plan[0] = mk_ld(5'd1, 2'd2, 1'b0, 2'd0);
        plan[1] = mk_alu(1'b1, 5'd2, 32'h0000_0111);
        plan[2] = mk_alu(1'b1, 5'd3, 32'h0000_0222);
        exp[0] = mk_out(1'b1, 5'd1, 32'h0000_0042);
        exp[1] = mk_out(1'b1, 5'd2, 32'h0000_0111);
        exp[2] = mk_out(1'b1, 5'd3, 32'h0000_0222);
        for (int c = 0; c < 12; c++) begin
            if (wrb_dec_vld === 1'b1) begin
                got.push_back(wrb_dec_pkt);
                if (first_cyc < 0) first_cyc = c;
            end
            if (c == 2 || c == 5) begin
                vec_cnt++;
                if (mem_wrb_stall !== 1'b1) begin err_cnt++; $display("FAIL stall_c%0d: got %b want 1", c, mem_wrb_stall); end
            end
            if (c == 6) begin
                vec_cnt++;
                if (mem_wrb_stall !== 1'b0) begin err_cnt++; $display("FAIL stall_c6: got %b want 0", mem_wrb_stall); end
            end
            if (issued < 3 && mem_wrb_stall !== 1'b1) begin
                mem_wrb_pkt = plan[issued]; mem_wrb_vld = 1'b1; issued++;
            end else begin
                mem_wrb_vld = 1'b0;
            end
            dmem_rsp_vld  = (c == 5);
            dmem_rsp_data = 32'h0000_0042;
            step();
        end
        mem_wrb_vld = 1'b0; dmem_rsp_vld = 1'b0; dmem_rsp_data = '0;
        vec_cnt++;
        if (first_cyc != 6) begin err_cnt++; $display("FAIL order_first_cycle: got %0d want 6", first_cyc); end
        vec_cnt++;
        if (got.size() != 3) begin
            err_cnt++; $display("FAIL order_count: got %0d want 3", got.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                vec_cnt++;
                if (got[k] !== exp[k]) begin err_cnt++; $display("FAIL order_%0d: got %h want %h", k, got[k], exp[k]); end
            end
        end
        $display("load+2alu: %0d outputs, first in cycle %0d", got.size(), first_cyc);
    endtask

    task automatic test_back_to_back();
        wrb_dec_pkt_t got [$];
        int           cyc [$];
        logic         stall_seen = 1'b0;
        for (int c = 0; c < 25; c++) begin
            if (wrb_dec_vld === 1'b1) begin got.push_back(wrb_dec_pkt); cyc.push_back(c); end
            if (mem_wrb_stall !== 1'b0) stall_seen = 1'b1;
            if (c < 20) begin
                mem_wrb_pkt = mk_alu(~c[0], 5'(c + 1), 32'hA000_0000 + 32'(c)); mem_wrb_vld = 1'b1;
            end else begin
                mem_wrb_vld = 1'b0;
            end
            step();
        end
        vec_cnt++;
        if (stall_seen !== 1'b0) begin err_cnt++; $display("FAIL b2b_stall: got 1 want 0"); end
        vec_cnt++;
        if (got.size() != 20) begin
            err_cnt++; $display("FAIL b2b_count: got %0d want 20", got.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                wrb_dec_pkt_t e;
                e = mk_out(~k[0], 5'(k + 1), 32'hA000_0000 + 32'(k));
                vec_cnt++;
                if (got[k] !== e || cyc[k] != k + 2) begin
                    err_cnt++; $display("FAIL b2b_%0d: got %h at cycle %0d want %h at cycle %0d", k, got[k], cyc[k], e, k + 2);
                end
            end
        end
        $display("back_to_back: %0d pulses", got.size());
    endtask

    task automatic test_reset_midop();
        wrb_dec_pkt_t exp;
        mem_wrb_pkt = mk_ld(5'd20, 2'd2, 1'b0, 2'd0); mem_wrb_vld = 1'b1;
        step();
        mem_wrb_pkt = mk_ld(5'd21, 2'd2, 1'b0, 2'd0);
        step();
        mem_wrb_vld = 1'b0;
        vec_cnt++;
        if (mem_wrb_stall !== 1'b1) begin err_cnt++; $display("FAIL midop_full: stall got %b want 1", mem_wrb_stall); end
        step();
        reset = 1'b1; dmem_rsp_vld = 1'b1; dmem_rsp_data = 32'h0000_0077;
        step();
        reset = 1'b0; dmem_rsp_vld = 1'b0; dmem_rsp_data = '0;
        vec_cnt++;
        if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL midop_vld: got %b want 0", wrb_dec_vld); end
        vec_cnt++;
        if (mem_wrb_stall !== 1'b0) begin err_cnt++; $display("FAIL midop_stall: got %b want 0", mem_wrb_stall); end
        exp = mk_out(1'b1, 5'd7, 32'h0BAD_F00D);
        mem_wrb_pkt = mk_alu(1'b1, 5'd7, 32'h0BAD_F00D); mem_wrb_vld = 1'b1;
        step(); mem_wrb_vld = 1'b0;
        vec_cnt++;
        if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL midop_alu_c1: vld got %b want 0", wrb_dec_vld); end
        step();
        vec_cnt++;
        if (wrb_dec_vld !== 1'b1 || wrb_dec_pkt !== exp) begin
            err_cnt++; $display("FAIL midop_alu_c2: got vld=%b pkt=%h want vld=1 pkt=%h", wrb_dec_vld, wrb_dec_pkt, exp);
        end
        // A fresh load must wait for its own response: no stale data survives reset.
        mem_wrb_pkt = mk_ld(5'd22, 2'd2, 1'b0, 2'd0); mem_wrb_vld = 1'b1;
        step(); mem_wrb_vld = 1'b0;
        for (int w = 0; w < 3; w++) begin
            vec_cnt++;
            if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL midop_ldwait%0d: vld got %b want 0", w, wrb_dec_vld); end
            step();
        end
        dmem_rsp_vld = 1'b1; dmem_rsp_data = 32'h0000_0099;
        step();
        dmem_rsp_vld = 1'b0; dmem_rsp_data = '0;
        exp = mk_out(1'b1, 5'd22, 32'h0000_0099);
        vec_cnt++;
        if (wrb_dec_vld !== 1'b1 || wrb_dec_pkt !== exp) begin
            err_cnt++; $display("FAIL midop_ld: got vld=%b pkt=%h want vld=1 pkt=%h", wrb_dec_vld, wrb_dec_pkt, exp);
        end
        $display("reset mid-op: recovered, load data=%h", wrb_dec_pkt.data);
        step();
    endtask

    task automatic test_rsp_buffer();
        wrb_dec_pkt_t exp;
        dmem_rsp_vld = 1'b1; dmem_rsp_data = 32'h0000_00AA;
        step();
        dmem_rsp_vld = 1'b0; dmem_rsp_data = '0;
        mem_wrb_pkt = mk_ld(5'd9, 2'd2, 1'b0, 2'd0); mem_wrb_vld = 1'b1;
        step();
        vec_cnt++;
        if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL buf_c2: vld got %b want 0", wrb_dec_vld); end
        mem_wrb_pkt = mk_ld(5'd10, 2'd2, 1'b0, 2'd0);
        dmem_rsp_vld = 1'b1; dmem_rsp_data = 32'h0000_0055;
        step();
        mem_wrb_vld = 1'b0; dmem_rsp_vld = 1'b0; dmem_rsp_data = '0;
        exp = mk_out(1'b1, 5'd9, 32'h0000_00AA);
        vec_cnt++;
        if (wrb_dec_vld !== 1'b1 || wrb_dec_pkt !== exp) begin
            err_cnt++; $display("FAIL buf_first: got vld=%b pkt=%h want vld=1 pkt=%h", wrb_dec_vld, wrb_dec_pkt, exp);
        end
        step();
        exp = mk_out(1'b1, 5'd10, 32'h0000_0055);
        vec_cnt++;
        if (wrb_dec_vld !== 1'b1 || wrb_dec_pkt !== exp) begin
            err_cnt++; $display("FAIL buf_second: got vld=%b pkt=%h want vld=1 pkt=%h", wrb_dec_vld, wrb_dec_pkt, exp);
        end
        step();
        vec_cnt++;
        if (wrb_dec_vld !== 1'b0) begin err_cnt++; $display("FAIL buf_idle: vld got %b want 0", wrb_dec_vld); end
        $display("rsp buffer: buffered word used before new response");
    endtask

    initial begin
        test_reset();
        test_alu_latency();
        test_load_align();
        test_load_stall();
        test_back_to_back();
        test_reset_midop();
        test_rsp_buffer();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
